cache_line_bank: RTL and testbench
==================================

Name: cache_line_bank

Overview:
- Parametrised cache data bank for one way of the L1 caches.
- Storage: 2^SET_BITS lines × 2^WORD_BITS 32-bit words, built as one inferred simple-dual-port RAM column per word.
- One write port, shared by CPU byte stores and a sequencing refill engine. The refill engine accepts one beat per cycle, critical word first, with wrap-around.
- One read port returning both the selected word and the whole line. Optional same-cycle store/refill-to-read forwarding. Optional clear-on-reset sweep.

Parameters:
- SET_BITS, 7, index width; number of lines = 2^SET_BITS.
- WORD_BITS, 3, word-offset width; words per line W = 2^WORD_BITS.
- CLEAR_ON_RESET, 0, 1 = zero every line after reset via an INIT sweep.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  1  read request; always accepted.
- rd_addr  in  SET_BITS+WORD_BITS  {set, word} read address.
- rd_valid  out  1  read data valid, one cycle after rd_req.
- rd_data  out  32  selected word.
- rd_line  out  32*W  whole line; word k at bits [32k+31:32k].
- st_req  in  1  store request.
- st_ready  out  1  store accepted when st_req & st_ready.
- st_addr  in  SET_BITS+WORD_BITS  store address.
- st_ben  in  4  byte enables; bit i maps to bits [8i+7:8i].
- st_data  in  32  store data.
- rf_start  in  1  begin refill (sampled in IDLE only).
- rf_set  in  SET_BITS  refill set.
- rf_word  in  WORD_BITS  first (critical) word of the refill.
- rf_valid  in  1  refill beat valid.
- rf_ready  out  1  beat accepted when rf_valid & rf_ready.
- rf_data  in  32  refill beat data.
- rf_done  out  1  one-cycle pulse after the last beat is written.
- busy  out  1  high in INIT or FILL.

Behaviour:
- Reset values: rd_valid=0, rd_data=0, rd_line=0, rf_done=0.
  - busy = 1 if CLEAR_ON_RESET=1, else 0.
  - State after reset: INIT if CLEAR_ON_RESET=1, else IDLE.
- Reset does not clear RAM unless CLEAR_ON_RESET=1. Reset mid-FILL abandons the refill; the partially written line keeps whatever beats were already written.
- States: INIT, IDLE, FILL.
  - INIT: a SET_BITS-wide counter writes zero to every word of set n, one set per cycle. After set 2^SET_BITS-1 the block goes to IDLE (2^SET_BITS cycles total). st_ready=0, rf_ready=0, rf_start ignored. Reads are served but return undefined data.
  - IDLE: st_ready=1, rf_ready=0. rf_start → FILL; latch set=rf_set, ptr=rf_word, beats=0. A store in the same cycle as rf_start still commits, and FILL starts next cycle. rf_valid is ignored.
  - FILL: rf_ready=1, st_ready=0, rf_start ignored. Each accepted beat writes rf_data to word ptr of the latched set with all bytes enabled. ptr = (ptr+1) mod W (wraps from W-1 to 0); beats++. The beat with beats==W-1 → IDLE, and rf_done pulses the following cycle. Gaps with rf_valid=0 are allowed; state is held.
- Write port per cycle: at most one write (init, refill beat, or store). A store writes only the bytes selected by st_ben in column st_addr word; other columns are untouched. st_ben=0 is accepted with no effect.
- Read port:
  - rd_req in cycle N reads all W columns at set rd_addr[top].
  - rd_line and rd_valid are registered and valid in cycle N+1.
  - rd_data is selected from rd_line by the word offset registered in cycle N.
  - Outputs hold their last value when rd_req=0; rd_valid=0 in that case.
- Read concurrent with a write to the same set in the same cycle: without the feature, RAM is read-first and returns old data.
- Read and write may target different sets in the same cycle with no interaction.

Optional Feature:
- Macro: CACHE_LINE_BANK_BYPASS_EN.
- Defined: if the write and read in cycle N hit the same set, rd_line in N+1 merges the written bytes per byte-enable over the RAM data, so rd_data reflects the new value. This applies to stores, refill beats, and init zeroes.
- Not defined: no merge logic; read-first old data is returned.

Test Plan:
- Defaults, CLEAR_ON_RESET=1: release rst, busy=1 for 128 cycles then 0; read set 5 word 2 → rd_data=0x00000000.
- Refill set 3, rf_word=5, beats 0xA0..0xA7 with a gap after beat 2 → words 5,6,7,0,1,2,3,4 = A0..A7; rf_done pulses once, 1 cycle after the 8th beat; rd_line word 0 = 0xA3.
- Store 0xDEADBEEF, ben=4'b0101, to set 3 word 0 (was 0x000000A3) → next read returns 0x00AD00EF. st_ready=0 during FILL, so a store held there is accepted the cycle after FILL ends.
- Same-cycle store 0x11223344 ben=4'hF and read, set 9 word 1 (old 0x0): bypass defined → 0x11223344; not defined → 0x00000000; next read → 0x11223344.
- Assert rst mid-refill after 3 beats (set 7, start word 6) → state IDLE, busy=0, rf_done never pulses; words 6,7,0 hold the beats written.
- rf_start during FILL with rf_set=4 → ignored; set 4 unchanged after completion.

Source files
------------

// File: rtl/cache_line_bank.sv
// cache_line_bank: one-way L1 data bank built from per-word dual-port RAM columns.
// Optional macro CACHE_LINE_BANK_BYPASS_EN merges same-cycle writes into the read result.
module cache_line_bank #(
   parameter int SET_BITS       = 7,
   parameter int WORD_BITS      = 3,
   parameter bit CLEAR_ON_RESET = 1'b0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               rd_req,
   input  logic [SET_BITS+WORD_BITS-1:0]      rd_addr,
   output logic                               rd_valid,
   output logic [31:0]                        rd_data,
   output logic [32*(2**WORD_BITS)-1:0]       rd_line,
   input  logic                               st_req,
   output logic                               st_ready,
   input  logic [SET_BITS+WORD_BITS-1:0]      st_addr,
   input  logic [3:0]                         st_ben,
   input  logic [31:0]                        st_data,
   input  logic                               rf_start,
   input  logic [SET_BITS-1:0]                rf_set,
   input  logic [WORD_BITS-1:0]               rf_word,
   input  logic                               rf_valid,
   output logic                               rf_ready,
   input  logic [31:0]                        rf_data,
   output logic                               rf_done,
   output logic                               busy
);
   localparam int W    = 2 ** WORD_BITS;
   localparam int SETS = 2 ** SET_BITS;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FILL} state_t;

   state_t               state;
   logic [SET_BITS-1:0]  init_cnt;
   logic [SET_BITS-1:0]  fill_set;
   logic [WORD_BITS-1:0] fill_ptr;
   logic [WORD_BITS-1:0] fill_beats;
   logic [WORD_BITS-1:0] rd_word_q;
   logic [SET_BITS-1:0]  rd_set;

   logic                 wr_en;
   logic                 wr_all;
   logic [SET_BITS-1:0]  wr_set;
   logic [WORD_BITS-1:0] wr_word;
   logic [3:0]           wr_ben;
   logic [31:0]          wr_data;
   logic                 st_fire;
   logic                 rf_fire;

   assign st_fire = st_req & st_ready;
   assign rf_fire = rf_valid & rf_ready;
   assign rd_set  = rd_addr[SET_BITS+WORD_BITS-1:WORD_BITS];

   // Single write port; the init sweep and refill beats can never coincide with an accepted store.
   always_comb begin
      wr_en   = 1'b0;
      wr_all  = 1'b0;
      wr_set  = st_addr[SET_BITS+WORD_BITS-1:WORD_BITS];
      wr_word = st_addr[WORD_BITS-1:0];
      wr_ben  = st_ben;
      wr_data = st_data;
      if (state == ST_INIT) begin
         wr_en   = 1'b1;
         wr_all  = 1'b1;
         wr_set  = init_cnt;
         wr_ben  = 4'hF;
         wr_data = '0;
      end else if (rf_fire) begin
         wr_en   = 1'b1;
         wr_set  = fill_set;
         wr_word = fill_ptr;
         wr_ben  = 4'hF;
         wr_data = rf_data;
      end else if (st_fire) begin
         wr_en   = 1'b1;
      end
   end

   for (genvar k = 0; k < W; k++) begin : g_col
      logic [31:0] mem [SETS];
      logic [3:0]  col_ben;
      logic [31:0] col_rd;
      logic [31:0] col_q;

      assign col_ben = (wr_en && (wr_all || wr_word == WORD_BITS'(k))) ? wr_ben : 4'h0;

      always_ff @(posedge clk) begin
         for (int b = 0; b < 4; b++) begin
            if (col_ben[b]) mem[wr_set][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end

`ifdef CACHE_LINE_BANK_BYPASS_EN
      always_comb begin
         col_rd = mem[rd_set];
         if (wr_set == rd_set) begin
            for (int b = 0; b < 4; b++) begin
               if (col_ben[b]) col_rd[8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end
`else
      assign col_rd = mem[rd_set];
`endif

      always_ff @(posedge clk or posedge rst) begin
         if (rst) col_q <= '0;
         else if (rd_req) col_q <= col_rd;
      end

      assign rd_line[32*k +: 32] = col_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid  <= 1'b0;
         rd_word_q <= '0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) rd_word_q <= rd_addr[WORD_BITS-1:0];
      end
   end

   assign rd_data = rd_line[32*rd_word_q +: 32];

   // Handshake flags are registered alongside the state so they change together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
         busy       <= CLEAR_ON_RESET;
         st_ready   <= !CLEAR_ON_RESET;
         rf_ready   <= 1'b0;
         rf_done    <= 1'b0;
         init_cnt   <= '0;
         fill_set   <= '0;
         fill_ptr   <= '0;
         fill_beats <= '0;
      end else begin
         rf_done <= 1'b0;
         case (state)
            ST_INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (init_cnt == SET_BITS'(SETS-1)) begin
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                  st_ready <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (rf_start) begin
                  state      <= ST_FILL;
                  busy       <= 1'b1;
                  st_ready   <= 1'b0;
                  rf_ready   <= 1'b1;
                  fill_set   <= rf_set;
                  fill_ptr   <= rf_word;
                  fill_beats <= '0;
               end
            end
            ST_FILL: begin
               if (rf_fire) begin
                  fill_ptr   <= fill_ptr + 1'b1;
                  fill_beats <= fill_beats + 1'b1;
                  if (fill_beats == WORD_BITS'(W-1)) begin
                     state    <= ST_IDLE;
                     busy     <= 1'b0;
                     st_ready <= 1'b1;
                     rf_ready <= 1'b0;
                     rf_done  <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               busy     <= 1'b0;
               st_ready <= 1'b1;
               rf_ready <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cache_line_bank.sv
`timescale 1ns/1ps
// Bench for cache_line_bank: one instance with and one without clear-on-reset, both
// driven alike and compared against an array model of the line contents.
module tb_cache_line_bank;
   localparam int SB   = 7;
   localparam int W    = 8;
   localparam int SETS = 128;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         rd_req, st_req, rf_start, rf_valid;
   logic [9:0]   rd_addr, st_addr;
   logic [3:0]   st_ben;
   logic [31:0]  st_data, rf_data;
   logic [SB-1:0] rf_set;
   logic [2:0]   rf_word;

   logic         rd_valid0, rd_valid1, st_ready0, st_ready1, rf_ready0, rf_ready1;
   logic         rf_done0, rf_done1, busy0, busy1;
   logic [31:0]  rd_data0, rd_data1;
   logic [255:0] rd_line0, rd_line1;

   int           total = 0;
   int           bad = 0;
   logic [31:0]  mem1 [SETS][W];
   logic [31:0]  mem0 [SETS][W];
   bit           known0 [SETS][W];
   logic [31:0]  last1;
   logic [31:0]  beat [W];

   always #5 clk = ~clk;

   cache_line_bank #(.SET_BITS(7), .WORD_BITS(3), .CLEAR_ON_RESET(1'b0)) dut0 (
      .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid0),
      .rd_data(rd_data0), .rd_line(rd_line0), .st_req(st_req), .st_ready(st_ready0),
      .st_addr(st_addr), .st_ben(st_ben), .st_data(st_data), .rf_start(rf_start),
      .rf_set(rf_set), .rf_word(rf_word), .rf_valid(rf_valid), .rf_ready(rf_ready0),
      .rf_data(rf_data), .rf_done(rf_done0), .busy(busy0));

   cache_line_bank #(.SET_BITS(7), .WORD_BITS(3), .CLEAR_ON_RESET(1'b1)) dut1 (
      .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid1),
      .rd_data(rd_data1), .rd_line(rd_line1), .st_req(st_req), .st_ready(st_ready1),
      .st_addr(st_addr), .st_ben(st_ben), .st_data(st_data), .rf_start(rf_start),
      .rf_set(rf_set), .rf_word(rf_word), .rf_valid(rf_valid), .rf_ready(rf_ready1),
      .rf_data(rf_data), .rf_done(rf_done1), .busy(busy1));

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] mkAddr(input int s, input int w);
      return 10'(s * W + w);
   endfunction

   function automatic logic [255:0] lineOf1(input int s);
      logic [255:0] l;
      for (int k = 0; k < W; k++) l[32*k +: 32] = mem1[s][k];
      return l;
   endfunction

   task automatic modelWrite(input int s, input int w, input logic [3:0] ben, input logic [31:0] d);
      for (int b = 0; b < 4; b++) begin
         if (ben[b]) begin
            mem1[s][w][8*b +: 8] = d[8*b +: 8];
            mem0[s][w][8*b +: 8] = d[8*b +: 8];
         end
      end
      if (ben == 4'hF) known0[s][w] = 1'b1;
   endtask

   // One clock: optional read, plus the write the bank is expected to perform this cycle.
   task automatic applyStimulus(input bit doRd, input logic [9:0] raddr, input bit wr,
                                input logic [9:0] waddr, input logic [3:0] wben, input logic [31:0] wdata);
      int rs, rw, ws;
      logic [255:0] expLine;
      logic [31:0] exp0;
      bit expK;
      rs = int'(raddr[9:3]);
      rw = int'(raddr[2:0]);
      ws = int'(waddr[9:3]);
      expLine = lineOf1(rs);
      exp0 = mem0[rs][rw];
      expK = known0[rs][rw];
      if (wr) modelWrite(ws, int'(waddr[2:0]), wben, wdata);
`ifdef CACHE_LINE_BANK_BYPASS_EN
      if (wr && ws == rs) begin
         expLine = lineOf1(rs);
         exp0 = mem0[rs][rw];
         expK = known0[rs][rw];
      end
`endif
      rd_req = doRd;
      rd_addr = raddr;
      @(posedge clk); #1;
      rd_req = 1'b0;
      checkOutput("rd_valid0", rd_valid0, doRd);
      if (doRd) begin
         checkOutput("rd_valid", rd_valid1, 1);
         checkOutput("rd_line", rd_line1, expLine);
         checkOutput("rd_data", rd_data1, expLine[32*rw +: 32]);
         last1 = expLine[32*rw +: 32];
         if (expK) begin
            checkOutput("rd_data0", rd_data0, exp0);
            checkOutput("rd_line0_word", rd_line0[32*rw +: 32], exp0);
         end
      end else begin
         checkOutput("rd_valid_low", rd_valid1, 0);
         checkOutput("rd_hold", rd_data1, last1);
      end
   endtask

   task automatic doStore(input logic [9:0] a, input logic [3:0] ben, input logic [31:0] d,
                          input bit doRd, input logic [9:0] ra);
      st_req = 1'b1; st_addr = a; st_ben = ben; st_data = d;
      checkOutput("st_ready", st_ready1, 1);
      applyStimulus(doRd, ra, 1'b1, a, ben, d);
      st_req = 1'b0;
   endtask

   task automatic randRead(input int s, output bit rdo, output logic [9:0] ra);
      rdo = 1'($urandom_range(0, 1));
      ra = mkAddr(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : s, $urandom_range(0, W-1));
   endtask

   // mode 0: plain, 1: store alongside rf_start, 2: store held through FILL
   task automatic doRefill(input int s, input int start, input logic [7:0] gap, input int mode,
                           input logic [9:0] sa, input logic [3:0] sben, input logic [31:0] sd,
                           input bit intrude);
      bit rdo;
      logic [9:0] ra;
      checkOutput("pre_fill_busy", busy1, 0);
      rf_start = 1'b1; rf_set = SB'(s); rf_word = 3'(start);
      if (mode == 1) begin st_req = 1'b1; st_addr = sa; st_ben = sben; st_data = sd; end
      applyStimulus(1'b0, 10'd0, mode == 1, sa, sben, sd);
      rf_start = 1'b0; st_req = 1'b0;
      if (mode == 2) begin st_req = 1'b1; st_addr = sa; st_ben = sben; st_data = sd; end
      for (int i = 0; i < W; i++) begin
         if (gap[i]) begin
            rf_valid = 1'b0;
            randRead(s, rdo, ra);
            applyStimulus(rdo, ra, 1'b0, 10'd0, 4'h0, 32'h0);
         end
         rf_valid = 1'b1; rf_data = beat[i];
         if (intrude && i == 3) begin rf_start = 1'b1; rf_set = SB'(4); end
         checkOutput("fill_rf_ready", rf_ready1, 1);
         checkOutput("fill_st_ready", st_ready1, 0);
         checkOutput("fill_busy", busy1, 1);
         checkOutput("fill_done_low", rf_done1, 0);
         randRead(s, rdo, ra);
         applyStimulus(rdo, ra, 1'b1, mkAddr(s, (start + i) % W), 4'hF, beat[i]);
         rf_start = 1'b0; rf_set = SB'(s);
      end
      rf_valid = 1'b0;
      checkOutput("rf_done_pulse", rf_done1, 1);
      checkOutput("rf_done_pulse0", rf_done0, 1);
      checkOutput("post_fill_busy", busy1, 0);
      checkOutput("post_fill_st_ready", st_ready1, 1);
      applyStimulus(1'b0, 10'd0, mode == 2, sa, sben, sd);
      st_req = 1'b0;
      checkOutput("rf_done_once", rf_done1, 0);
   endtask

   task automatic waitInit(input string tag);
      int n;
      int doneSeen;
      n = 0;
      doneSeen = 0;
      while (busy1 && n < 1000) begin
         @(posedge clk); #1;
         n++;
         if (rf_done0 || rf_done1) doneSeen++;
      end
      checkOutput(tag, n, 128);
      checkOutput("init_no_done", doneSeen, 0);
      checkOutput("init_busy0", busy0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit rdo;
      logic [9:0] ra, sa;
      logic [3:0] ben;
      int op;
      rd_req = 0; rd_addr = 0; st_req = 0; st_addr = 0; st_ben = 0; st_data = 0;
      rf_start = 0; rf_set = 0; rf_word = 0; rf_valid = 0; rf_data = 0;
      last1 = 32'h0;
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < W; w++) begin
            mem1[s][w] = 32'h0; mem0[s][w] = 32'h0; known0[s][w] = 1'b0;
         end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_rd_valid", rd_valid1, 0);
      checkOutput("rst_rd_data", rd_data1, 0);
      checkOutput("rst_rd_line", rd_line1, 0);
      checkOutput("rst_rf_done", rf_done1, 0);
      checkOutput("rst_busy1", busy1, 1);
      checkOutput("rst_busy0", busy0, 0);
      checkOutput("rst_st_ready1", st_ready1, 0);
      checkOutput("rst_st_ready0", st_ready0, 1);
      checkOutput("rst_rf_ready0", rf_ready0, 0);
      rst = 1'b0;
      waitInit("init_cycles");

      applyStimulus(1'b1, mkAddr(5, 2), 1'b0, 10'd0, 4'h0, 32'h0);
      checkOutput("clear_set5", rd_data1, 32'h0);

      // Same-cycle store and read to set 9 word 1.
      doStore(mkAddr(9, 1), 4'hF, 32'h11223344, 1'b1, mkAddr(9, 1));
`ifdef CACHE_LINE_BANK_BYPASS_EN
      checkOutput("same_cycle_rd", rd_data1, 32'h11223344);
`else
      checkOutput("same_cycle_rd", rd_data1, 32'h00000000);
`endif
      applyStimulus(1'b1, mkAddr(9, 1), 1'b0, 10'd0, 4'h0, 32'h0);
      checkOutput("after_store_rd", rd_data1, 32'h11223344);

      for (int i = 0; i < W; i++) beat[i] = 32'hA0 + i;
      doRefill(3, 5, 8'b0000_1000, 0, 10'd0, 4'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, mkAddr(3, 0), 1'b0, 10'd0, 4'h0, 32'h0);
      checkOutput("refill_word0", rd_data1, 32'h000000A3);
      checkOutput("refill_word5", rd_line1[32*5 +: 32], 32'h000000A0);
      doStore(mkAddr(3, 0), 4'b0101, 32'hDEADBEEF, 1'b0, 10'd0);
      applyStimulus(1'b1, mkAddr(3, 0), 1'b0, 10'd0, 4'h0, 32'h0);
      checkOutput("byte_store", rd_data1, 32'h00AD00EF);

      // Store held through a refill lands after it, on the refilled set.
      for (int i = 0; i < W; i++) beat[i] = 32'hB0B0_0000 + i;
      doRefill(10, 2, 8'b0010_0001, 2, mkAddr(10, 3), 4'b1100, 32'hCAFE0000, 1'b0);
      applyStimulus(1'b1, mkAddr(10, 3), 1'b0, 10'd0, 4'h0, 32'h0);
      checkOutput("held_store", rd_data1, 32'hCAFE0001);

      for (int w = 0; w < W; w++) doStore(mkAddr(4, w), 4'hF, 32'h44000000 + w, 1'b0, 10'd0);
      for (int i = 0; i < W; i++) beat[i] = 32'h66000000 + i;
      doRefill(6, 1, 8'h00, 0, 10'd0, 4'h0, 32'h0, 1'b1);
      for (int w = 0; w < W; w++) applyStimulus(1'b1, mkAddr(4, w), 1'b0, 10'd0, 4'h0, 32'h0);
      checkOutput("intrude_set4", rd_data1, 32'h44000007);

      for (int it = 0; it < 400; it++) begin
         op = $urandom_range(0, 19);
         sa = mkAddr($urandom_range(0, 15), $urandom_range(0, W-1));
         ben = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
         if (op < 2) begin
            for (int i = 0; i < W; i++) beat[i] = $urandom;
            doRefill($urandom_range(0, 15), $urandom_range(0, W-1), 8'($urandom),
                     $urandom_range(0, 2), sa, ben, $urandom, 1'b0);
         end else if (op < 10) begin
            randRead(int'(sa[9:3]), rdo, ra);
            doStore(sa, ben, $urandom, rdo, ra);
         end else begin
            applyStimulus(1'($urandom_range(0, 3) != 0), mkAddr($urandom_range(0, 15),
                          $urandom_range(0, W-1)), 1'b0, 10'd0, 4'h0, 32'h0);
         end
      end

      // Reset in the middle of a refill of set 7 from word 6.
      rf_start = 1'b1; rf_set = SB'(7); rf_word = 3'd6;
      applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 4'h0, 32'h0);
      rf_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rf_valid = 1'b1; rf_data = 32'h77000000 + i;
         applyStimulus(1'b0, 10'd0, 1'b1, mkAddr(7, (6 + i) % W), 4'hF, 32'h77000000 + i);
      end
      rf_valid = 1'b0;
      rst = 1'b1;
      #2;
      checkOutput("midrst_busy0", busy0, 0);
      checkOutput("midrst_st_ready0", st_ready0, 1);
      checkOutput("midrst_rf_ready0", rf_ready0, 0);
      checkOutput("midrst_rf_done0", rf_done0, 0);
      checkOutput("midrst_busy1", busy1, 1);
      rst = 1'b0;
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < W; w++) mem1[s][w] = 32'h0;
      last1 = 32'h0;
      waitInit("reinit_cycles");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, mkAddr(7, (6 + i) % W), 1'b0, 10'd0, 4'h0, 32'h0);
         checkOutput("midrst_word", rd_data0, 32'h77000000 + i);
         checkOutput("midrst_cleared", rd_data1, 32'h0);
      end
      checkOutput("midrst_idle", st_ready0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
